// File: rtl/clk_gate_ctrl.sv
// Clock-gate sequencer: merges per-requester clock requests, applies a wake-up
// settling delay before acking and idle hysteresis before gating the branch off.
module clk_gate_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_on,
  output logic [NUM_REQ-1:0] ack,
  output logic               gate_en,
  output logic               busy,
  output logic [1:0]         state_o,
  output logic [15:0]        on_count
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 gate_en_q, gate_en_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [15:0]          on_count_q, on_count_d;
  logic                 any_req;

  assign any_req = (|req) | force_on;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (any_req) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      // WAKE always runs to completion so the gate never chatters mid-settle.
      ST_WAKE: begin
        if (cnt_q == WAKE_LAST) state_d = ST_ON;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      ST_ON: begin
        if (!any_req) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (any_req)                 state_d = ST_ON;
        else if (cnt_q == IDLE_LAST) state_d = ST_OFF;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_OFF;
    endcase

    // Outputs are registered from next state so gate_en is a clean flop output.
    gate_en_d  = (state_d != ST_OFF);
    ack_d      = (state_d == ST_ON) ? req : '0;
    on_count_d = (gate_en_q && (on_count_q != 16'hFFFF)) ? on_count_q + 16'd1 : on_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      gate_en_q  <= 1'b0;
      ack_q      <= '0;
      on_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gate_en_q  <= gate_en_d;
      ack_q      <= ack_d;
      on_count_q <= on_count_d;
    end
  end

  assign gate_en  = gate_en_q;
  assign busy     = gate_en_q;
  assign ack      = ack_q;
  assign state_o  = state_q;
  assign on_count = on_count_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: behavioural model of gate age / quiet time compared
// every cycle, plus directed literal expectations for the key sequences.
module tb_clk_gate_ctrl;

  localparam int NUM_REQ = 4;
  localparam int WAKE    = 4;
  localparam int IDLE    = 8;

  logic               clk;
  logic               rst_n;
  logic [NUM_REQ-1:0] req;
  logic               force_on;
  logic [NUM_REQ-1:0] ack;
  logic               gate_en;
  logic               busy;
  logic [1:0]         state_o;
  logic [15:0]        on_count;

  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];

  clk_gate_ctrl #(
    .NUM_REQ(NUM_REQ), .WAKE_CYCLES(WAKE), .IDLE_CYCLES(IDLE), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .force_on(force_on),
    .ack(ack), .gate_en(gate_en), .busy(busy), .state_o(state_o), .on_count(on_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: gate on/off, cycles the gate has been up, and consecutive quiet
  // samples taken once the clock is settled.
  typedef struct {
    bit gate;
    int age;
    int quiet;
    int oncnt;
  } mdl_t;

  mdl_t               m;
  logic [NUM_REQ-1:0] m_req_q;

  function automatic mdl_t mdl_step(mdl_t cur, logic any);
    mdl_t nx = cur;
    if (cur.gate && cur.oncnt != 32'hFFFF) nx.oncnt = cur.oncnt + 1;
    if (!cur.gate) begin
      if (any) begin
        nx.gate  = 1'b1;
        nx.age   = 1;
        nx.quiet = 0;
      end
    end else if (cur.age <= WAKE) begin
      nx.age = cur.age + 1;
    end else begin
      nx.quiet = any ? 0 : cur.quiet + 1;
      if (nx.quiet == IDLE + 1) nx.gate = 1'b0;
    end
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= '{gate: 1'b0, age: 0, quiet: 0, oncnt: 0};
      m_req_q <= '0;
    end else begin
      m       <= mdl_step(m, (|req) | force_on);
      m_req_q <= req;
    end
  end

  function automatic int exp_state();
    if (!m.gate)       return 0;
    if (m.age <= WAKE) return 1;
    if (m.quiet == 0)  return 2;
    return 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_gate_en", 32'(gate_en), 32'(m.gate));
      chk("m_busy", 32'(busy), 32'(m.gate));
      chk("m_state", 32'(state_o), 32'(exp_state()));
      chk("m_ack", 32'(ack), (exp_state() == 2) ? 32'(m_req_q) : 32'd0);
      chk("m_on_count", 32'(on_count), 32'(m.oncnt));
    end
  end

  // Driver tasks
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_off(input string name);
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (state_o == 2'd0) break;
    end
    chk(name, 32'(state_o), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 4'hF;
    force_on = 1'b0;

    // Reset held with requests asserted
    repeat (3) cyc();
    chk("rst_gate_en", 32'(gate_en), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_on_count", 32'(on_count), 0);
    rst_n = 1'b1;
    req   = '0;
    repeat (2) cyc();

    // Wake latency
    req = 4'b0001;
    exp_q = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("wake_state", 32'(state_o), 32'(exp_q.pop_front()));
      chk("wake_gate", 32'(gate_en), 1);
      chk("wake_ack", 32'(ack), (k == 5) ? 32'd1 : 32'd0);
    end

    // Idle timeout
    req = '0;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      if (k == 1) begin
        chk("idle_ack", 32'(ack), 0);
        chk("idle_state", 32'(state_o), 3);
      end
      if (k <= 8) chk("idle_gate", 32'(gate_en), 1);
      if (k == 9) begin
        chk("off_gate", 32'(gate_en), 0);
        chk("off_state", 32'(state_o), 0);
        chk("off_on_count", 32'(on_count), 13);
      end
    end

    // Re-request during IDLE goes straight back to ON
    req = 4'b0001;
    repeat (5) cyc();
    req = '0;
    repeat (4) cyc();
    req = 4'b0100;
    cyc();
    chk("rereq_state", 32'(state_o), 2);
    chk("rereq_ack", 32'(ack), 4'b0100);
    req = '0;
    wait_off("rereq_off");

    // One-cycle request pulse during WAKE still completes the sequence
    begin
      bit saw_on = 1'b0;
      bit saw_idle = 1'b0;
      req = 4'b0001;
      cyc();
      req = '0;
      for (int i = 0; i < 40; i++) begin
        cyc();
        if (state_o == 2'd2) saw_on = 1'b1;
        if (state_o == 2'd3) saw_idle = 1'b1;
        if (state_o == 2'd0) break;
      end
      chk("pulse_saw_on", 32'(saw_on), 1);
      chk("pulse_saw_idle", 32'(saw_idle), 1);
      chk("pulse_off", 32'(state_o), 0);
    end

    // Multiple requesters
    req = 4'b0101;
    repeat (5) cyc();
    chk("multi_ack", 32'(ack), 4'b0101);
    req = 4'b0100;
    cyc();
    chk("multi_drop0_ack", 32'(ack), 4'b0100);
    chk("multi_drop0_state", 32'(state_o), 2);
    req = '0;
    cyc();
    chk("multi_idle_state", 32'(state_o), 3);
    chk("multi_idle_ack", 32'(ack), 0);
    wait_off("multi_off");

    // Randomized traffic with variable hold times
    for (int seg = 0; seg < 120; seg++) begin
      int hold;
      hold = $urandom_range(1, 14);
      req = ($urandom_range(0, 99) < 45) ? 4'h0 : 4'($urandom_range(0, 15));
      force_on = ($urandom_range(0, 99) < 8);
      repeat (hold) cyc();
    end
    req = '0;
    force_on = 1'b0;
    wait_off("rand_off");

    // force_on only: clock held on with no ack; counter saturates
    force_on = 1'b1;
    repeat (5) cyc();
    chk("force_state", 32'(state_o), 2);
    chk("force_ack", 32'(ack), 0);
    chk("force_gate", 32'(gate_en), 1);
    repeat (70000) cyc();
    chk("sat_on_count", 32'(on_count), 16'hFFFF);
    cyc();
    chk("sat_hold", 32'(on_count), 16'hFFFF);

    // Asynchronous reset mid-ON, checked before any clock edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gate_en", 32'(gate_en), 0);
    chk("arst_ack", 32'(ack), 0);
    chk("arst_on_count", 32'(on_count), 0);
    chk("arst_state", 32'(state_o), 0);
    repeat (2) cyc();
    force_on = 1'b0;
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("post_arst_state", 32'(state_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
